// File: rtl/dense_mac_engine_if.sv
// rtl/dense_mac_engine_if.sv - control, parameter-memory and activation/result bus of the dense MAC engine
interface dense_mac_engine_if #(
  parameter int DATSIZE = 22,
  parameter int PARSIZE = 16
);
  // layer control
  logic               start;
  logic               layer;
  logic               relu;
  logic               busy;
  logic               done;
  // weight / bias parameter modules
  logic [3:0]         p_state;
  logic               w_en;
  logic [6:0]         read_o;
  logic [7:0]         read_i;
  logic [PARSIZE-1:0] w_data;
  logic [PARSIZE-1:0] b_data;
  // activation source and result sink
  logic               act_en;
  logic [7:0]         act_addr;
  logic [DATSIZE-1:0] act_data;
  logic               out_we;
  logic [6:0]         out_addr;
  logic [DATSIZE-1:0] out_data;

  modport master (
    input  start, layer, relu, w_data, b_data, act_data,
    output busy, done, p_state, w_en, read_o, read_i, act_en, act_addr,
           out_we, out_addr, out_data
  );

  modport slave (
    output start, layer, relu, w_data, b_data, act_data,
    input  busy, done, p_state, w_en, read_o, read_i, act_en, act_addr,
           out_we, out_addr, out_data
  );
endinterface

// File: rtl/dense_mac_engine.sv
// rtl/dense_mac_engine.sv - dense layer sequencer and MAC datapath; DENSE_SAT_EN selects clamping over wrap-around
module dense_mac_engine #(
  parameter int DATSIZE = 22,
  parameter int PARSIZE = 16,
  parameter int FPSHIFT = 14,
  parameter int ACCSIZE = DATSIZE + PARSIZE + 8
) (
  input  logic               clk,
  input  logic               rst,
  dense_mac_engine_if.master bus
);
  localparam int         PRODSIZE = DATSIZE + PARSIZE;
  localparam logic [6:0] LAST_O   = 7'd95;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                    state_q;
  logic                      layer_q;
  logic                      relu_q;
  logic                      vld_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      w_en_q;
  logic                      out_we_q;
  logic [3:0]                p_state_q;
  logic [6:0]                read_o_q;
  logic [6:0]                out_addr_q;
  logic [7:0]                read_i_q;
  logic [DATSIZE-1:0]        out_data_q;
  logic [DATSIZE-1:0]        out_data_d;
  logic signed [ACCSIZE-1:0] acc_q;
  logic signed [ACCSIZE-1:0] acc_d;

  logic [7:0]                last_i;
  logic signed [PRODSIZE-1:0] prod;
  logic signed [ACCSIZE-1:0] prod_ext;
  logic signed [ACCSIZE-1:0] bias_ext;

  // last input index of the latched layer: 96 inputs for DENSE1, 256 for DENSE2
  assign last_i   = layer_q ? 8'd95 : 8'd255;
  assign prod     = $signed(bus.w_data) * $signed(bus.act_data);
  assign prod_ext = {{(ACCSIZE-PRODSIZE){prod[PRODSIZE-1]}}, prod};
  assign bias_ext = {{(ACCSIZE-PARSIZE-FPSHIFT){bus.b_data[PARSIZE-1]}}, bus.b_data, {FPSHIFT{1'b0}}};

  // accumulator next state: bias preload on the first fetch, then one product per returned beat
  always_comb begin
    acc_d = acc_q;
    if (state_q == S_FETCH && read_i_q == 8'd0) begin
      acc_d = bias_ext;
    end else if (vld_q) begin
      acc_d = acc_q + prod_ext;
    end
  end

`ifdef DENSE_SAT_EN
  logic signed [ACCSIZE-1:0] shifted;

  // rescale to DATSIZE with clamping to the representable range, then optional ReLU
  always_comb begin
    shifted = acc_d >>> FPSHIFT;
    if (!shifted[ACCSIZE-1] && (|shifted[ACCSIZE-2:DATSIZE-1])) begin
      out_data_d = {1'b0, {(DATSIZE-1){1'b1}}};
    end else if (shifted[ACCSIZE-1] && !(&shifted[ACCSIZE-2:DATSIZE-1])) begin
      out_data_d = {1'b1, {(DATSIZE-1){1'b0}}};
    end else begin
      out_data_d = shifted[DATSIZE-1:0];
    end
    if (relu_q && out_data_d[DATSIZE-1]) begin
      out_data_d = '0;
    end
  end
`else
  // rescale to DATSIZE keeping the low bits (wrap-around), then optional ReLU
  always_comb begin
    out_data_d = DATSIZE'(acc_d >>> FPSHIFT);
    if (relu_q && out_data_d[DATSIZE-1]) begin
      out_data_d = '0;
    end
  end
`endif

  // layer sequencer with registered outputs; the valid flag trails the fetch by the 1-cycle memory latency
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      layer_q    <= 1'b0;
      relu_q     <= 1'b0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      w_en_q     <= 1'b0;
      out_we_q   <= 1'b0;
      p_state_q  <= 4'd0;
      read_o_q   <= 7'd0;
      read_i_q   <= 8'd0;
      out_addr_q <= 7'd0;
      out_data_q <= '0;
      acc_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      vld_q      <= (state_q == S_FETCH);
      done_q     <= 1'b0;
      out_we_q   <= 1'b0;
      out_data_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            layer_q   <= bus.layer;
            relu_q    <= bus.relu;
            read_o_q  <= 7'd0;
            read_i_q  <= 8'd0;
            busy_q    <= 1'b1;
            w_en_q    <= 1'b1;
            p_state_q <= {3'b100, bus.layer};
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (read_i_q == last_i) begin
            w_en_q  <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            read_i_q <= read_i_q + 8'd1;
          end
        end
        S_DRAIN: begin
          out_we_q   <= 1'b1;
          out_addr_q <= read_o_q;
          out_data_q <= out_data_d;
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          if (read_o_q == LAST_O) begin
            p_state_q <= 4'd0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            read_o_q <= read_o_q + 7'd1;
            read_i_q <= 8'd0;
            w_en_q   <= 1'b1;
            state_q  <= S_FETCH;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.p_state  = p_state_q;
  assign bus.w_en     = w_en_q;
  assign bus.act_en   = w_en_q;
  assign bus.read_o   = read_o_q;
  assign bus.read_i   = read_i_q;
  assign bus.act_addr = read_i_q;
  assign bus.out_we   = out_we_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_data = out_data_q;
endmodule

// File: tb/tb_dense_mac_engine.sv
// tb/tb_dense_mac_engine.sv - scoreboard bench for dense_mac_engine
`timescale 1ns/1ps
module tb_dense_mac_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dense_mac_engine_if #(.DATSIZE(22), .PARSIZE(16)) bus ();

  dense_mac_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [6:0]  addr;
    logic [21:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  mode  = 0;
  int  wc    = 0;
  int  ac    = 0;
  int  bc    = 0;

  function automatic int wfn(int o, int i);
    if (mode == 0) return wc;
    return ((o * 37 + i * 11) % 2001) - 1000;
  endfunction

  function automatic int afn(int i);
    if (mode == 0) return ac;
    return ((i * 53) % 4001) - 2000;
  endfunction

  function automatic int bfn(int o);
    if (mode == 0) return bc;
    return ((o * 97) % 8001) - 4000;
  endfunction

  // reference result of one output neuron
  function automatic logic [21:0] model(bit lay, bit rl, int o);
    longint acc;
    longint sh;
    logic [21:0] r;
    int nin;
    nin = lay ? 96 : 256;
    acc = longint'(bfn(o)) * 64'sd16384;
    for (int i = 0; i < nin; i++) acc += longint'(wfn(o, i)) * longint'(afn(i));
    sh = acc >>> 14;
`ifdef DENSE_SAT_EN
    if (sh > 64'sd2097151) r = 22'h1FFFFF;
    else if (sh < -64'sd2097152) r = 22'h200000;
    else r = sh[21:0];
`else
    r = sh[21:0];
`endif
    if (rl && r[21]) r = 22'd0;
    return r;
  endfunction

  // weight and activation memories: one cycle read latency
  always @(posedge clk) begin
    if (bus.w_en === 1'b1) bus.w_data <= 16'(wfn(int'(bus.read_o), int'(bus.read_i)));
    if (bus.act_en === 1'b1) bus.act_data <= 22'(afn(int'(bus.act_addr)));
  end

  // bias module: combinational on the neuron index
  always_comb bus.b_data = 16'(bfn(int'(bus.read_o)));

  task automatic kick(input bit lay, input bit rl);
    exp_q.delete();
    for (int o = 0; o < 96; o++) exp_q.push_back('{addr: 7'(o), data: model(lay, rl, o)});
    @(negedge clk);
    bus.start = 1'b1;
    bus.layer = lay;
    bus.relu  = rl;
    @(negedge clk);
    bus.start = 1'b0;
    bus.layer = ~lay;
    bus.relu  = ~rl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.w_en, bus.act_en, bus.out_we} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_strobes got %b required 00000", {bus.busy, bus.done, bus.w_en, bus.act_en, bus.out_we});
    end
    n_cmp++;
    if (bus.p_state !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_p_state got %h required 0", bus.p_state);
    end
    n_cmp++;
    if (bus.read_o !== 7'd0 || bus.out_addr !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_out_index got read_o=%0d out_addr=%0d required 0/0", bus.read_o, bus.out_addr);
    end
    n_cmp++;
    if (bus.read_i !== 8'd0 || bus.act_addr !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_in_index got read_i=%0d act_addr=%0d required 0/0", bus.read_i, bus.act_addr);
    end
    n_cmp++;
    if (bus.out_data !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_out_data got %h required 0", bus.out_data);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.p_state !== 4'd0) begin
      n_bad++;
      $display("FAIL idle_no_start got busy=%b p_state=%h required 0/0", bus.busy, bus.p_state);
    end
  endtask

  task automatic test_layer(input string name, input bit lay, input bit rl, input bit inject);
    int nin;
    int dcyc;
    int rel;
    int o;
    int writes;
    int dones;
    int done_at;
    int seq_bad;
    int first_bad;
    bit injected;
    bit ok;
    logic [3:0] ps_exp;
    wr_t e;
    nin       = lay ? 96 : 256;
    dcyc      = 1 + 96 * (nin + 2);
    writes    = 0;
    dones     = 0;
    done_at   = -1;
    seq_bad   = 0;
    first_bad = -1;
    injected  = 1'b0;
    ps_exp    = {3'b100, lay};
    kick(lay, rl);
    for (int n = 1; n <= dcyc + 5; n++) begin
      rel = (n - 1) % (nin + 2);
      o   = (n - 1) / (nin + 2);
      if (n < dcyc)
        ok = bus.busy === 1'b1 && bus.done === 1'b0 && bus.w_en === (rel < nin) &&
             bus.act_en === (rel < nin) && bus.read_o === 7'(o) && bus.p_state === ps_exp &&
             bus.out_we === (rel == nin + 1) &&
             (rel >= nin || (bus.read_i === 8'(rel) && bus.act_addr === 8'(rel)));
      else if (n == dcyc)
        ok = bus.busy === 1'b1 && bus.done === 1'b1 && bus.w_en === 1'b0 && bus.act_en === 1'b0 &&
             bus.out_we === 1'b0 && bus.p_state === 4'd0;
      else
        ok = bus.busy === 1'b0 && bus.done === 1'b0 && bus.w_en === 1'b0 && bus.act_en === 1'b0 &&
             bus.out_we === 1'b0 && bus.p_state === 4'd0;
      if (bus.out_we !== 1'b1 && bus.out_data !== 22'd0) ok = 1'b0;
      if (int'(bus.read_i) >= nin || int'(bus.read_o) > 95) ok = 1'b0;
      if (!ok) begin
        seq_bad++;
        if (first_bad < 0) first_bad = n;
      end
      if (bus.out_we === 1'b1) begin
        writes++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s_extra_write got addr %0d required no further write", name, bus.out_addr);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (bus.out_addr !== e.addr) begin
            n_bad++;
            $display("FAIL %s_addr got %0d required %0d", name, bus.out_addr, e.addr);
          end
          n_cmp++;
          if (bus.out_data !== e.data) begin
            n_bad++;
            $display("FAIL %s_data[%0d] got %h required %h", name, e.addr, bus.out_data, e.data);
          end
        end
      end
      if (bus.done === 1'b1) begin
        dones++;
        if (done_at < 0) done_at = n;
      end
      bus.start = 1'b0;
      if (inject && !injected && n < dcyc && bus.read_o === 7'd5) begin
        bus.start = 1'b1;
        injected  = 1'b1;
      end
      if (inject && n == dcyc) bus.start = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_cmp++;
    if (writes != 96) begin
      n_bad++;
      $display("FAIL %s_write_count got %0d required 96", name, writes);
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL %s_done_count got %0d required 1", name, dones);
    end
    n_cmp++;
    if (done_at != dcyc) begin
      n_bad++;
      $display("FAIL %s_done_cycle got t0+%0d required t0+%0d", name, done_at, dcyc);
    end
    n_cmp++;
    if (seq_bad != 0) begin
      n_bad++;
      $display("FAIL %s_sequence got %0d bad cycles (first t0+%0d) required 0", name, seq_bad, first_bad);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    int wr;
    int dn;
    int bz;
    wr_t e;
    mode = 1;
    kick(1'b1, 1'b0);
    n = 1;
    while (bus.read_o !== 7'd10 && n < 2000) begin
      if (bus.out_we === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.out_addr !== e.addr || bus.out_data !== e.data) begin
          n_bad++;
          $display("FAIL pre_reset_write got %0d:%h required %0d:%h", bus.out_addr, bus.out_data, e.addr, e.data);
        end
      end
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (bus.read_o !== 7'd10) begin
      n_bad++;
      $display("FAIL reach_neuron10 got read_o=%0d required 10 within 2000 cycles", bus.read_o);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.w_en, bus.act_en, bus.out_we, bus.done} !== 5'b0) begin
      n_bad++;
      $display("FAIL mid_reset_strobes got %b required 00000", {bus.busy, bus.w_en, bus.act_en, bus.out_we, bus.done});
    end
    rst = 1'b0;
    wr = 0;
    dn = 0;
    bz = 0;
    repeat (400) begin
      @(negedge clk);
      if (bus.out_we === 1'b1) wr++;
      if (bus.done === 1'b1) dn++;
      if (bus.busy !== 1'b0) bz++;
    end
    n_cmp++;
    if (wr != 0 || dn != 0 || bz != 0) begin
      n_bad++;
      $display("FAIL post_reset_quiet got writes=%0d dones=%0d busy_cycles=%0d required 0/0/0", wr, dn, bz);
    end
    exp_q.delete();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.layer = 1'b0;
    bus.relu  = 1'b0;
    test_reset();
    mode = 0; wc = 16384; ac = 1; bc = 0;
    test_layer("d1_unity", 1'b1, 1'b0, 1'b0);
    wc = 0; bc = -16384;
    test_layer("d1_negbias", 1'b1, 1'b0, 1'b0);
    test_layer("d1_negbias_relu_restart", 1'b1, 1'b1, 1'b1);
    wc = 16384; ac = 1 << 20; bc = 0;
    test_layer("d2_overflow", 1'b0, 1'b0, 1'b0);
    test_mid_reset();
    test_layer("d1_after_reset", 1'b1, 1'b0, 1'b0);
    test_layer("d1_pattern_relu", 1'b1, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dense_mac_engine.md
Name: dense_mac_engine

Overview:
- Sequencer and MAC datapath for the fully connected layers. Consumes dense_weights (1-cycle BRAM latency) and dense_biases (combinational).
- Drives their state, read_o, read_i and en inputs, reads activations from the upstream activation buffer, and writes one DATSIZE result per output neuron to the downstream buffer.
- Each start computes one full layer: DENSE2 (256->96) or DENSE1 (96->96).

Parameters:
- DATSIZE, 22, activation/result width (signed, FPSHIFT fractional bits)
- PARSIZE, 16, weight/bias width (signed, FPSHIFT fractional bits)
- FPSHIFT, 14, fixed-point fraction bits
- ACCSIZE, 46, accumulator width (DATSIZE+PARSIZE+8)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin layer; accepted only in IDLE
- layer  in  1  0=DENSE2 (256 in), 1=DENSE1 (96 in); sampled with start
- relu  in  1  apply ReLU to results; sampled with start
- busy  out  1  high from FETCH through DONE
- done  out  1  one-cycle pulse after last write
- p_state  out  4  to param modules: 4'b1000 DENSE2, 4'b1001 DENSE1, 4'b0000 otherwise
- w_en  out  1  weight BRAM enable
- read_o  out  7  output neuron index
- read_i  out  8  input index
- w_data  in  PARSIZE  weight, valid 1 cycle after w_en
- b_data  in  PARSIZE  bias for current p_state/read_o, combinational
- act_en  out  1  activation read enable
- act_addr  out  8  activation index (= read_i)
- act_data  in  DATSIZE  activation, valid 1 cycle after act_en
- out_we  out  1  result write strobe
- out_addr  out  7  result index
- out_data  out  DATSIZE  result

Behaviour:
- Reset: state=IDLE; busy, done, w_en, act_en, out_we = 0; p_state, read_o, read_i, act_addr, out_addr, out_data, accumulator = 0. rst overrides everything, including mid-layer: the next cycle is IDLE, no done, no further writes.
- N_IN = 256 (layer=0) or 96 (layer=1). N_OUT = 96.
- IDLE: start=1 latches layer and relu, read_o=0, read_i=0, goes to FETCH. start in any other state is ignored.
- FETCH, cycle k = 0..N_IN-1:
  - w_en = act_en = 1; read_i = act_addr = k.
  - At k=0, acc <= sign-extended b_data <<< FPSHIFT.
  - Valid flag delayed by 1 cycle. When set, acc <= acc + w_data*act_data (signed 38-bit product, sign-extended to ACCSIZE).
  - After k = N_IN-1, go to DRAIN.
- DRAIN, 1 cycle: w_en = act_en = 0; the final product is accumulated.
- WRITE, 1 cycle:
  - out_we = 1, out_addr = read_o.
  - out_data = acc >>> FPSHIFT (arithmetic, floor), then saturated or truncated per the optional feature, then ReLU (negative -> 0) if relu was latched.
  - If read_o = 95, go to DONE. Else read_o += 1, read_i = 0, go to FETCH.
- DONE, 1 cycle: done = 1, busy = 1. Then IDLE with busy = 0.
- Outside WRITE: out_we = 0 and out_data = 0.
- p_state is nonzero only in FETCH, DRAIN and WRITE.
- Cycle counts: each neuron takes N_IN+2 cycles. With start sampled at edge t0, done is high in cycle t0 + 1 + 96*(N_IN+2): t0+9409 for DENSE1, t0+24769 for DENSE2.
- read_i never exceeds N_IN-1; read_o never exceeds 95.

Optional Feature:
- DENSE_SAT_EN defined: the shifted result is clamped to [-2^(DATSIZE-1), 2^(DATSIZE-1)-1] before ReLU.
- Undefined: the low DATSIZE bits are taken (wrap-around); there is no clamp logic.

Test Plan:
- DENSE1: all weights 16384, all act_data 1, biases 0, relu=0 -> 96 writes, out_addr 0..95 in order, each out_data=96; done single pulse at t0+9409.
- DENSE1: weights 0, bias -16384. relu=0 -> out_data=22'h3FC000 (-16384). relu=1 -> out_data=0.
- DENSE2: weights 16384, act_data 2^20.
  - With DENSE_SAT_EN -> out_data=2097151.
  - Without -> out_data=0 (2^28 wraps).
  - Done at t0+24769.
- Sequence check: per neuron, read_i 0..N_IN-1 with w_en=act_en=1, then exactly 2 cycles with w_en=0; p_state=4'b1000 for DENSE2 and 4'b1001 for DENSE1 during compute, 0 in IDLE.
- Assert rst while read_o=10 -> next cycle busy=0, w_en=0, out_we=0; done never pulses. A fresh start then completes all 96 writes correctly.
- Pulse start again at read_o=5 and during the DONE cycle -> ignored; exactly 96 writes and one done. Only a start sampled in IDLE launches a new layer.
